// File: rtl/regfile_ctrl.sv
// Sequencer that fetches two operands from an 8x8 register file, executes a small ALU op
// and writes the result back. Define REGFILE_CTRL_LOADI_FAST_EN to let LOADI skip the operand read.
module regfile_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  REG_OUT1ADDRESS,
    output logic [2:0]  REG_OUT2ADDRESS,
    input  logic [7:0]  REG_OUT1,
    input  logic [7:0]  REG_OUT2,
    output logic [2:0]  REG_INADDRESS,
    output logic [7:0]  REG_IN,
    output logic        REG_WRITE,
    output logic        DONE,
    output logic        ERROR,
    output logic [2:0]  state_dbg
);

    // Handshake: an instruction is taken on a rising CLK edge where INSTR_VALID and
    // INSTR_READY are both 1; INSTR_READY is high only in IDLE and INSTR is ignored otherwise.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] opcode_q;
    logic [2:0] dest_q;
    logic [2:0] src1_q;
    logic [2:0] src2_q;
    logic [7:0] imm_q;
    logic [7:0] result_q;
    logic [7:0] alu_result;
    logic       legal;
    logic       accept;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

    assign accept    = INSTR_VALID && (state == IDLE);
    assign legal     = (opcode_q <= OP_OR);
    assign state_dbg = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (INSTR_VALID) begin
`ifdef REGFILE_CTRL_LOADI_FAST_EN
                    state_nxt = (INSTR[31:24] == OP_LOADI) ? WRITE : READ;
`else
                    state_nxt = READ;
`endif
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state only; reset forces IDLE at once, so a write in flight is dropped.
    always_comb begin
        INSTR_READY = 1'b0;
        REG_WRITE   = 1'b0;
        DONE        = 1'b0;
        ERROR       = 1'b0;
        case (state)
            IDLE:  INSTR_READY = 1'b1;
            WRITE: begin
                DONE      = 1'b1;
                REG_WRITE = legal;
                ERROR     = !legal;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_result = 8'h00;
        case (opcode_q)
            OP_LOADI: alu_result = imm_q;
            OP_MOV:   alu_result = REG_OUT2;
            OP_ADD:   alu_result = REG_OUT1 + REG_OUT2;
            OP_SUB:   alu_result = REG_OUT1 - REG_OUT2;
            OP_AND:   alu_result = REG_OUT1 & REG_OUT2;
            OP_OR:    alu_result = REG_OUT1 | REG_OUT2;
            default:  alu_result = 8'h00;
        endcase
    end

    // Fields are captured once at accept, so the read addresses stay put until the next accept.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            opcode_q <= 8'h00;
            dest_q   <= 3'b000;
            src1_q   <= 3'b000;
            src2_q   <= 3'b000;
            imm_q    <= 8'h00;
        end else if (accept) begin
            opcode_q <= INSTR[31:24];
            dest_q   <= INSTR[18:16];
            src1_q   <= INSTR[10:8];
            src2_q   <= INSTR[2:0];
            imm_q    <= INSTR[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            result_q <= 8'h00;
`ifdef REGFILE_CTRL_LOADI_FAST_EN
        end else if (accept && (INSTR[31:24] == OP_LOADI)) begin
            result_q <= INSTR[7:0];
`endif
        end else if (state == EXEC) begin
            result_q <= alu_result;
        end
    end

    assign REG_OUT1ADDRESS = src1_q;
    assign REG_OUT2ADDRESS = src2_q;
    assign REG_INADDRESS   = dest_q;
    assign REG_IN          = result_q;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 INSTR  input  32  instruction word: [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] immediate; other bits ignored.
REQ-005 INSTR_VALID  input  1  INSTR holds a valid instruction.
REQ-006 INSTR_READY  output  1  block can accept an instruction.
REQ-007 REG_OUT1ADDRESS  output  3  register file read port 1 address.
REQ-008 REG_OUT2ADDRESS  output  3  register file read port 2 address.
REQ-009 REG_OUT1  input  8  register file read port 1 data.
REQ-010 REG_OUT2  input  8  register file read port 2 data.
REQ-011 REG_INADDRESS  output  3  register file write address.
REQ-012 REG_IN  output  8  register file write data.
REQ-013 REG_WRITE  output  1  register file write enable, sampled by the register file on CLK rising edge.
REQ-014 DONE  output  1  one-cycle pulse when an instruction retires.
REQ-015 ERROR  output  1  one-cycle pulse when an illegal opcode retires.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, EXEC, WRITE.
REQ-017 INSTR_READY SHALL be 1 only in IDLE; an instruction SHALL be accepted and latched on a rising edge where INSTR_VALID=1 and INSTR_READY=1, and the FSM SHALL move IDLE->READ.
REQ-018 Transitions SHALL be READ->WAIT->EXEC->WRITE->IDLE, one cycle each; the instruction-accept-to-accept interval is 5 cycles.
REQ-019 From READ through WRITE, REG_OUT1ADDRESS=src1 and REG_OUT2ADDRESS=src2 of the latched instruction, held stable; in IDLE both SHALL hold their last values.
REQ-020 WAIT covers register-file read latency; REG_OUT1/REG_OUT2 SHALL be sampled only on the rising edge that ends EXEC, and the result SHALL be registered.
REQ-021 Opcodes: 0x00 LOADI result=immediate; 0x01 MOV result=REG_OUT2; 0x02 ADD result=REG_OUT1+REG_OUT2; 0x03 SUB result=REG_OUT1-REG_OUT2; 0x04 AND; 0x05 OR.
REQ-022 Arithmetic SHALL be 8-bit modulo 256; carry and borrow SHALL be discarded.
REQ-023 In WRITE for a legal opcode: REG_WRITE=1, REG_INADDRESS=dest, REG_IN=result, DONE=1.
REQ-024 In WRITE for an opcode 0x06-0xFF: REG_WRITE=0, DONE=1, ERROR=1; no register changes.
REQ-025 REG_WRITE SHALL be 0 in every state other than WRITE.
REQ-026 INSTR/INSTR_VALID changes outside IDLE SHALL be ignored.
REQ-027 dest equal to src1 or src2 SHALL be legal; operands are read before the write.

Reset
REQ-028 RESET=1 SHALL immediately force state IDLE, REG_WRITE=0, DONE=0, ERROR=0, all address outputs 3'b000, REG_IN=8'h00, latched result 8'h00.
REQ-029 INSTR_READY SHALL be 1 while in IDLE after reset, including while RESET is held.
REQ-030 Reset asserted mid-instruction, including in WRITE, SHALL abort it with no write and no DONE pulse.

Configuration
REQ-031 Macro REGFILE_CTRL_LOADI_FAST_EN: when defined, LOADI SHALL go IDLE->WRITE directly, giving a 2-cycle accept-to-accept interval; all other opcodes are unchanged.
REQ-032 When REGFILE_CTRL_LOADI_FAST_EN is undefined, LOADI SHALL traverse all five states like other opcodes.

Verification
REQ-033 Bench SHALL connect regfile_ctrl to an 8x8 register file model with 2-port read and 1 write port, clocked on CLK.
REQ-034 Reset then LOADI r2=0x1F: REG_WRITE=1, REG_INADDRESS=2, REG_IN=0x1F in WRITE; DONE pulses; r2 reads 0x1F.
REQ-035 LOADI r1=0xF0, LOADI r3=0x20, ADD r4=r1+r3: r4=0x10 (wrap). SUB r5=r3-r1: r5=0x30.
REQ-036 Opcode 0x7A: DONE=1 and ERROR=1 in the same cycle; REG_WRITE stays 0; all registers unchanged.
REQ-037 RESET asserted during EXEC of ADD r6: REG_WRITE never asserts; r6 unchanged; INSTR_READY=1 after reset.
REQ-038 INSTR_VALID held high with back-to-back LOADIs: accept interval is 5 cycles without REGFILE_CTRL_LOADI_FAST_EN and 2 cycles with it.
